// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
//   Feeds the 8-to-3 priority encoder in the interrupt path. It synchronises
//   eight asynchronous request lines and latches each one as pending, either
//   on a rising edge or while the level is high. It then presents a frozen,
//   masked snapshot to the encoder, holds it until the consumer acks, and
//   clears the serviced bit using the encoder's index.
//
//   Ports
//     clk, rst_n  system clock (rising edge), async active-low reset
//     req[7:0]    async request lines (bit 7 highest downstream priority)
//     mask[7:0]   1 = keep bit out of the snapshot (still recorded as pending)
//     edge_mode   per bit: 1 = rising-edge latch, 0 = level latch
//     clr_all     synchronous clear of all pending/handshake state
//     ack,ack_idx single-cycle ack and the encoder index being serviced
//     pend_out    frozen masked snapshot (encoder Din)
//     irq_valid   pend_out is a nonzero snapshot awaiting ack
//     pend_raw    live unmasked pending register
//     ack_err     sticky: an ack named a bit absent from the snapshot

// Per-bit synchroniser, history flop and event detect.
module irq_sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   input  logic edge_sel,
   output logic set
);
   logic [SYNC_STAGES-1:0] sff;
   logic                   prev;
   logic                   sync;

   assign sync = sff[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sff  <= '0;
         prev <= 1'b0;
      end else begin
         sff  <= {sff[SYNC_STAGES-2:0], din};
         prev <= sync;
      end
   end

   assign set = edge_sel ? (sync & ~prev) : sync;
endmodule

module irq_pending_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] mask,
   input  logic [7:0] edge_mode,
   input  logic       clr_all,
   input  logic       ack,
   input  logic [2:0] ack_idx,
   output logic [7:0] pend_out,
   output logic       irq_valid,
   output logic [7:0] pend_raw,
   output logic       ack_err
);
   typedef enum logic [1:0] {IDLE, REQ, CLEAR} state_t;

   state_t     state, state_n;
   logic [7:0] set;
   logic [7:0] masked;
   logic [7:0] pend_raw_n, pend_out_n;
   logic       ack_err_n;
   logic [2:0] idx_q, idx_n;
   logic       clr_vld, clr_vld_n;   // the ack that led into CLEAR hit a snapshot bit

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit
         irq_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .din      (req[gi]),
            .edge_sel (edge_mode[gi]),
            .set      (set[gi])
         );
      end
   endgenerate

   assign masked    = pend_raw & ~mask;
   assign irq_valid = (state == REQ);

   always_comb begin
      state_n    = state;
      pend_raw_n = pend_raw | set;
      pend_out_n = pend_out;
      ack_err_n  = ack_err;
      idx_n      = idx_q;
      clr_vld_n  = clr_vld;

      case (state)
         IDLE: begin
            pend_out_n = '0;
            if (masked != '0) begin
               pend_out_n = masked;
               state_n    = REQ;
            end
         end
         REQ: begin
            // pend_out stays frozen here; only an ack moves us on
            if (ack) begin
               idx_n      = ack_idx;
               clr_vld_n  = pend_out[ack_idx];
               if (!pend_out[ack_idx]) ack_err_n = 1'b1;
               pend_out_n = '0;
               state_n    = CLEAR;
            end
         end
         CLEAR: begin
            pend_out_n = '0;
            // an event landing on the serviced bit in this cycle survives
            if (clr_vld) pend_raw_n[idx_q] = set[idx_q];
            state_n = IDLE;
         end
         default: begin
            pend_out_n = '0;
            state_n    = IDLE;
         end
      endcase

      // clr_all overrides everything, including same-cycle events
      if (clr_all) begin
         pend_raw_n = '0;
         pend_out_n = '0;
         ack_err_n  = 1'b0;
         clr_vld_n  = 1'b0;
         state_n    = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pend_raw <= '0;
         pend_out <= '0;
         ack_err  <= 1'b0;
         idx_q    <= '0;
         clr_vld  <= 1'b0;
      end else begin
         state    <= state_n;
         pend_raw <= pend_raw_n;
         pend_out <= pend_out_n;
         ack_err  <= ack_err_n;
         idx_q    <= idx_n;
         clr_vld  <= clr_vld_n;
      end
   end
endmodule
